multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of cycles spent waiting for mem_ready per access (range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 7, instruction register bits [6:0], valid from DECODE onward.
REQ-005 SHALL have port mem_ready, input, 1, memory completes the current read/write this cycle.
REQ-006 SHALL have ports iord, memread, memwrite, irwrite, pcwrite, pcwritecond, pcsrc, alusrca, regwrite, memtoreg: each an output of 1 bit, the datapath enable or select of the same name.
REQ-007 SHALL have ports alusrcb and aluop, outputs, 2 bits each: ALU B-mux select (00 reg, 01 const 4, 10 imm, 11 branch offset) and ALU control class (00 add, 01 sub/compare, 10 funct-decoded).
REQ-008 SHALL have port instr_done, output, 1, one-cycle pulse on instruction retirement.
REQ-009 SHALL have port trap, output, 2, cause: 00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-010 SHALL implement a Moore FSM with states START, FETCH, DECODE, ADDR, MEM_RD, MEM_WR, LD_WB, EXEC_R, R_WB, BRANCH, HALT; irwrite and pcwrite in FETCH are additionally gated by mem_ready.
REQ-011 SHALL leave START unconditionally to FETCH after one cycle, with all outputs 0.
REQ-012 In FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, irwrite=pcwrite=mem_ready; it SHALL remain in FETCH until mem_ready=1, then go to DECODE.
REQ-013 In DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00, and branch on opcode: 0110011 -> EXEC_R; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; any other value -> HALT with trap=01.
REQ-014 In ADDR SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to MEM_RD for 0000011 or MEM_WR for 0100011.
REQ-015 In MEM_RD SHALL drive memread=1, iord=1, holding until mem_ready=1, then go to LD_WB; in MEM_WR it SHALL drive memwrite=1, iord=1, holding until mem_ready=1, then go to FETCH.
REQ-016 In LD_WB SHALL drive regwrite=1, memtoreg=1; in EXEC_R alusrca=1, alusrcb=00, aluop=10; in R_WB regwrite=1, memtoreg=0; LD_WB, EXEC_R and R_WB SHALL each last one cycle, with EXEC_R -> R_WB and both write-back states -> FETCH.
REQ-017 In BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=1 for one cycle, then go to FETCH.
REQ-018 SHALL pulse instr_done in the last cycle of LD_WB, R_WB, BRANCH and of MEM_WR when mem_ready=1.
REQ-019 SHALL drive every output not listed for a state to 0.
REQ-020 SHALL count wait cycles in FETCH, MEM_RD and MEM_WR with an 8-bit counter, cleared on state entry and on mem_ready; on reaching MEM_TIMEOUT-1 with mem_ready=0 it SHALL go to HALT with trap=10.
REQ-021 SHALL give mem_ready=1 on the timeout cycle priority over timeout: the access completes normally.
REQ-022 In HALT SHALL drive all enables 0 and hold trap until reset, ignoring all inputs.
REQ-023 Latency with mem_ready constantly 1 SHALL be: R 4, ld 5, sd 4, beq 3 cycles, each from FETCH entry to FETCH re-entry.

Reset
REQ-024 While rst_n=0, SHALL force state START, wait counter 0, trap 00, and all outputs 0, asynchronously.
REQ-025 Reset asserted mid-instruction SHALL abort it with no further enable asserted; after release the sequence restarts at START.

Structure
REQ-026 SHALL take state encodings, opcode constants, alusrcb/aluop encodings and trap codes from shared package rv_ctrl_pkg.
REQ-027 SHALL place the wait counter in sub-module mem_wait_timer (inputs clr, en; output expired).

Verification
REQ-028 R-type 0110011, mem_ready=1 -> states START,FETCH,DECODE,EXEC_R,R_WB; regwrite=1 only in R_WB; instr_done one pulse; 4 cycles.
REQ-029 ld 0000011, data ready after 3 wait cycles -> MEM_RD held 4 cycles with iord=1, then LD_WB with memtoreg=1, regwrite=1.
REQ-030 beq 1100011 -> BRANCH with pcwritecond=1, pcsrc=1, aluop=01 for one cycle, back in FETCH on cycle 3.
REQ-031 opcode 0010111 at DECODE -> HALT, trap=01, all enables 0 for 20 further cycles.
REQ-032 mem_ready stuck 0 in FETCH with MEM_TIMEOUT=16 -> HALT, trap=10, on the 16th FETCH cycle; mem_ready=1 on that cycle -> DECODE instead.
REQ-033 rst_n low during MEM_WR -> memwrite drops to 0 in the same cycle; after release: START then FETCH.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operand/class selects and trap causes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    START,
    FETCH,
    DECODE,
    ADDR,
    MEM_RD,
    MEM_WR,
    LD_WB,
    EXEC_R,
    R_WB,
    BRANCH,
    HALT
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_ILLEGAL = 2'b01,
    TRAP_TIMEOUT = 2'b10
  } trap_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags when the wait budget is used up.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  // Wait counter: cleared on request, otherwise advances while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: Moore FSM sequencing fetch, decode,
// memory, ALU and write-back steps, with memory-wait timeout and trap reporting.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       pcsrc,
  output logic       alusrca,
  output logic       regwrite,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic [1:0] trap
);

  state_t state, state_next;
  trap_t  trap_q, trap_next;
  logic   wait_en, timer_clr, expired;

  // The counter is zero on entry to any wait state: it is held clear in every
  // non-wait state, and every exit from a wait state happens on a clear.
  assign timer_clr = mem_ready || !wait_en || (state_next != state);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (wait_en),
    .expired(expired)
  );

  // State and trap-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= START;
      trap_q <= TRAP_NONE;
    end else begin
      state  <= state_next;
      trap_q <= trap_next;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next  = state;
    trap_next   = trap_q;
    wait_en     = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsrc       = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    alusrcb     = SRCB_REG;
    aluop       = ALU_ADD;
    instr_done  = 1'b0;
    case (state)
      START: state_next = FETCH;
      FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        wait_en = 1'b1;
        if (mem_ready) begin
          state_next = DECODE;
        end else if (expired) begin
          state_next = HALT;
          trap_next  = TRAP_TIMEOUT;
        end
      end
      DECODE: begin
        alusrcb = SRCB_BOFF;
        case (opcode)
          OP_RTYPE:           state_next = EXEC_R;
          OP_LOAD, OP_STORE:  state_next = ADDR;
          OP_BRANCH:          state_next = BRANCH;
          default: begin
            state_next = HALT;
            trap_next  = TRAP_ILLEGAL;
          end
        endcase
      end
      ADDR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        memread = 1'b1;
        iord    = 1'b1;
        wait_en = 1'b1;
        if (mem_ready) begin
          state_next = LD_WB;
        end else if (expired) begin
          state_next = HALT;
          trap_next  = TRAP_TIMEOUT;
        end
      end
      MEM_WR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        wait_en    = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          state_next = FETCH;
        end else if (expired) begin
          state_next = HALT;
          trap_next  = TRAP_TIMEOUT;
        end
      end
      LD_WB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      EXEC_R: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_REG;
        aluop      = ALU_FUNCT;
        state_next = R_WB;
      end
      R_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_REG;
        aluop       = ALU_SUB;
        pcwritecond = 1'b1;
        pcsrc       = 1'b1;
        instr_done  = 1'b1;
        state_next  = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = START;
    endcase
  end

  assign trap = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-by-cycle vector table walking
// R/ld/sd/beq/illegal instructions, plus halt-hold, timeout and reset sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       iord, memread, memwrite, irwrite, pcwrite, pcwritecond, pcsrc;
  logic       alusrca, regwrite, memtoreg, instr_done;
  logic [1:0] alusrcb, aluop, trap;
  logic [16:0] outs;

  int passed = 0;
  int total  = 0;

  multicycle_ctrl #(
    .MEM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pcwritecond(pcwritecond),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .instr_done (instr_done),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  // {iord,memread,memwrite,irwrite,pcwrite,pcwritecond,pcsrc,alusrca,
  //  regwrite,memtoreg,alusrcb[1:0],aluop[1:0],instr_done,trap[1:0]}
  assign outs = {iord, memread, memwrite, irwrite, pcwrite, pcwritecond, pcsrc,
                 alusrca, regwrite, memtoreg, alusrcb, aluop, instr_done, trap};

  localparam logic [16:0] E_IDLE   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_00;
  localparam logic [16:0] E_FETCH1 = 17'b0_1_0_1_1_0_0_0_0_0_01_00_0_00;
  localparam logic [16:0] E_FETCH0 = 17'b0_1_0_0_0_0_0_0_0_0_01_00_0_00;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_0_00;
  localparam logic [16:0] E_EXEC_R = 17'b0_0_0_0_0_0_0_1_0_0_00_10_0_00;
  localparam logic [16:0] E_R_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_1_00;
  localparam logic [16:0] E_ADDR   = 17'b0_0_0_0_0_0_0_1_0_0_10_00_0_00;
  localparam logic [16:0] E_MEM_RD = 17'b1_1_0_0_0_0_0_0_0_0_00_00_0_00;
  localparam logic [16:0] E_LD_WB  = 17'b0_0_0_0_0_0_0_0_1_1_00_00_1_00;
  localparam logic [16:0] E_MEMWR0 = 17'b1_0_1_0_0_0_0_0_0_0_00_00_0_00;
  localparam logic [16:0] E_MEMWR1 = 17'b1_0_1_0_0_0_0_0_0_0_00_00_1_00;
  localparam logic [16:0] E_BRANCH = 17'b0_0_0_0_0_1_1_1_0_0_00_01_1_00;
  localparam logic [16:0] E_HALT_I = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_01;
  localparam logic [16:0] E_HALT_T = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_10;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] IL = 7'b0010111;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Called at posedge+1: drive inputs, sample mid-cycle, advance to next posedge+1.
  task automatic step(input logic [6:0] op, input logic mr, input logic [16:0] exp,
                      input string name);
    opcode    = op;
    mem_ready = mr;
    #3;
    check(name, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    #1;
    check("reset_outputs", outs, E_IDLE);
    @(posedge clk);
    #1;
    check("reset_held", outs, E_IDLE);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;

    tbl.push_back('{R,  1'b0, E_IDLE,   "start"});
    tbl.push_back('{R,  1'b1, E_FETCH1, "r_fetch"});
    tbl.push_back('{R,  1'b0, E_DECODE, "r_decode"});
    tbl.push_back('{R,  1'b0, E_EXEC_R, "r_exec"});
    tbl.push_back('{R,  1'b0, E_R_WB,   "r_wb"});
    tbl.push_back('{LD, 1'b1, E_FETCH1, "ld_fetch"});
    tbl.push_back('{LD, 1'b0, E_DECODE, "ld_decode"});
    tbl.push_back('{LD, 1'b0, E_ADDR,   "ld_addr"});
    tbl.push_back('{LD, 1'b0, E_MEM_RD, "ld_memrd_w1"});
    tbl.push_back('{LD, 1'b0, E_MEM_RD, "ld_memrd_w2"});
    tbl.push_back('{LD, 1'b0, E_MEM_RD, "ld_memrd_w3"});
    tbl.push_back('{LD, 1'b1, E_MEM_RD, "ld_memrd_rdy"});
    tbl.push_back('{LD, 1'b0, E_LD_WB,  "ld_wb"});
    tbl.push_back('{SD, 1'b1, E_FETCH1, "sd_fetch"});
    tbl.push_back('{SD, 1'b0, E_DECODE, "sd_decode"});
    tbl.push_back('{SD, 1'b0, E_ADDR,   "sd_addr"});
    tbl.push_back('{SD, 1'b0, E_MEMWR0, "sd_memwr_wait"});
    tbl.push_back('{SD, 1'b1, E_MEMWR1, "sd_memwr_rdy"});
    tbl.push_back('{BQ, 1'b0, E_FETCH0, "beq_fetch_wait"});
    tbl.push_back('{BQ, 1'b1, E_FETCH1, "beq_fetch"});
    tbl.push_back('{BQ, 1'b0, E_DECODE, "beq_decode"});
    tbl.push_back('{BQ, 1'b0, E_BRANCH, "beq_branch"});
    tbl.push_back('{IL, 1'b1, E_FETCH1, "ill_fetch"});
    tbl.push_back('{IL, 1'b0, E_DECODE, "ill_decode"});

    // Vector table run
    do_reset();
    foreach (tbl[i]) step(tbl[i].op, tbl[i].mr, tbl[i].exp, tbl[i].name);

    // Halt holds trap=01 with enables low regardless of inputs
    for (int i = 0; i < 20; i++)
      step(7'($urandom), 1'($urandom), E_HALT_I, "halt_illegal_hold");

    // Fetch timeout: 16 wait cycles then HALT with trap=10
    do_reset();
    step(R, 1'b0, E_IDLE, "to_start");
    for (int i = 0; i < 16; i++) step(R, 1'b0, E_FETCH0, "to_fetch_wait");
    step(R, 1'b1, E_HALT_T, "to_halt");
    step(R, 1'b1, E_HALT_T, "to_halt_hold");

    // mem_ready on the 16th cycle wins over timeout
    do_reset();
    step(R, 1'b0, E_IDLE, "edge_start");
    for (int i = 0; i < 15; i++) step(R, 1'b0, E_FETCH0, "edge_fetch_wait");
    step(R, 1'b1, E_FETCH1, "edge_fetch_rdy");
    step(R, 1'b0, E_DECODE, "edge_decode");
    step(R, 1'b0, E_EXEC_R, "edge_exec");

    // Reset asserted mid-store drops memwrite immediately, then restarts
    do_reset();
    step(SD, 1'b0, E_IDLE,   "rst_start");
    step(SD, 1'b1, E_FETCH1, "rst_fetch");
    step(SD, 1'b0, E_DECODE, "rst_decode");
    step(SD, 1'b0, E_ADDR,   "rst_addr");
    mem_ready = 1'b0;
    #1;
    check("rst_memwr_active", outs, E_MEMWR0);
    rst_n = 1'b0;
    #1;
    check("rst_memwr_abort", outs, E_IDLE);
    @(posedge clk);
    #1;
    check("rst_low_idle", outs, E_IDLE);
    rst_n = 1'b1;
    step(SD, 1'b0, E_IDLE,   "rst_restart_start");
    step(SD, 1'b1, E_FETCH1, "rst_restart_fetch");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
